uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_transmitter` between `NumRequesters` independent byte sources on the ice40 uncore. Each requester presents a byte with a valid/ready handshake. The arbiter selects one requester fairly and issues a single-cycle `tx_byte_valid` pulse to the transmitter. It then follows the transmitter's `tx_byte_done` through one full byte before granting again. It sits between host-side producers (XLS result streamer, debug/status printer) and the UART transmitter's `tx_byte`/`tx_byte_valid`/`tx_byte_done_out` ports.

## Interface

Parameters:
- `NumRequesters`, default 4: number of requesters, legal range 2..8.
- `GrantIdWidth`, default `$clog2(NumRequesters)`: width of `grant_id`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NumRequesters  bit i: requester i has a byte pending.
- `req_byte`  in  8*NumRequesters  requester i's byte at bits [8i+7:8i].
- `req_ready`  out  NumRequesters  one-hot grant; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `tx_byte`  out  8  byte to the transmitter.
- `tx_byte_valid`  out  1  single-cycle issue pulse to the transmitter.
- `tx_byte_done`  in  1  transmitter idle/done indication (high = idle).
- `busy`  out  1  high whenever state != IDLE.
- `grant_id`  out  GrantIdWidth  index of the most recently granted requester.
- `sent_count`  out  16  bytes completed since reset, wraps 0xFFFF->0.

## Operation

- States:
  - IDLE: grant offered.
  - ISSUE: pulse to the transmitter.
  - WAIT_LOW: wait for the transmitter to accept.
  - WAIT_HIGH: wait for the byte to complete.
- IDLE:
  - `req_ready` is combinational. It is the one-hot of the winner when `tx_byte_done==1` and `|req_valid`, else all zero.
  - Winner: the first set `req_valid` bit searching upward from `rr_ptr`, wrapping at NumRequesters-1 -> 0.
  - On a grant: latch `req_byte[winner]` into `tx_byte`, set `grant_id=winner`, set `rr_ptr=(winner+1) mod NumRequesters`, go to ISSUE.
- ISSUE: `tx_byte_valid=1` for exactly this cycle, then go to WAIT_LOW unconditionally.
- WAIT_LOW: `tx_byte_valid=0`. Stay until `tx_byte_done==0`, then go to WAIT_HIGH.
- WAIT_HIGH: stay until `tx_byte_done==1`. Then increment `sent_count` and go to IDLE.
- `tx_byte` holds its latched value from grant until the next grant. It never changes while state != IDLE.
- `req_valid` changes outside IDLE do not affect the in-flight byte.
- A requester dropping `req_valid` in IDLE before a grant loses nothing. It is simply not selected.
- Only one grant is allowed per pass through IDLE. `tx_byte_valid` is never high for two consecutive cycles and is never high outside ISSUE. This prevents a second acceptance during the transmitter's stop bit.

## Timing

- Reset values (asynchronous, effective immediately while `rst_n==0`):
  - state=IDLE, `tx_byte=8'h00`, `tx_byte_valid=0`, `busy=0`, `grant_id=0`, `rr_ptr=0`, `sent_count=0`.
  - `req_ready` follows the IDLE rule, so it is 0 while `tx_byte_done==0`.
- Latency: grant in cycle G (IDLE, combinational `req_ready`); `tx_byte_valid` high in cycle G+1. The transmitter drops `tx_byte_done` at G+2.
- Inter-byte gap: after `tx_byte_done` rises, the arbiter is in IDLE the next cycle. Back-to-back bytes are therefore spaced by transmit time + 2 cycles.
- `tx_byte_done` low while in IDLE (transmitter driven elsewhere or still finishing): no grant; wait.
- All requesters valid: strict rotation 0,1,...,N-1,0. No requester waits more than N-1 grants.
- Reset mid-byte: the arbiter returns to IDLE and the latched byte is dropped. If the transmitter was not also reset, the arbiter waits in IDLE for `tx_byte_done==1` before granting.

## Test plan

- Single request. Reset, then `req_valid=4'b0100`, `req_byte[23:16]=8'h55`, `tx_byte_done=1`:
  - `req_ready=4'b0100` the same cycle.
  - `tx_byte=8'h55` with `tx_byte_valid` high exactly 1 cycle, next cycle.
  - `grant_id=2`.
  - After the transmitter completes, `sent_count=1` and `busy=0`.
- Round-robin. All four valid with bytes 0xA0..0xA3 held, real `uart_transmitter` with ClocksPerBaud=2:
  - Bytes appear on `tx` in order A0, A1, A2, A3, A0.
  - `grant_id` sequence 0,1,2,3,0.
- Pointer fairness. Grant requester 3 first, then assert `req_valid=4'b1001`: the next grant goes to 0, not 3.
- No double issue. With the transmitter accepting early during its stop bit, and requester 1 continuously valid:
  - `tx_byte_valid` is never high 2 consecutive cycles.
  - Each byte is transmitted exactly once.
  - `sent_count` equals the number of `req_ready` handshakes.
- Busy transmitter. Hold `tx_byte_done=0` in IDLE with `req_valid=4'b0001`: `req_ready` stays 0. Raise `tx_byte_done`: grant the same cycle.
- Reset mid-operation. Assert `rst_n=0` during WAIT_HIGH:
  - All outputs take their reset values immediately.
  - `sent_count=0`.
  - The next grant after reset goes to requester 0 if valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART transmitter between NumRequesters byte sources.
// Latency: grant (combinational req_ready) in cycle G, tx_byte_valid pulse in G+1.
// Backpressure: no grant unless IDLE with tx_byte_done high; one byte in flight, held until the transmitter finishes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake, req_ready is a one-hot grant
//   req_byte           requester i's byte at [8i+7:8i]
//   tx_byte/_valid     byte and single-cycle issue pulse to the transmitter
//   tx_byte_done       transmitter idle (high) / busy (low)
//   busy               arbiter not in IDLE
//   grant_id           most recently granted requester
//   sent_count         bytes completed since reset (wrapping)
module uart_tx_arbiter #(
  parameter int NumRequesters = 4,
  parameter int GrantIdWidth  = $clog2(NumRequesters)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NumRequesters-1:0]   req_valid,
  input  logic [8*NumRequesters-1:0] req_byte,
  output logic [NumRequesters-1:0]   req_ready,
  output logic [7:0]                 tx_byte,
  output logic                       tx_byte_valid,
  input  logic                       tx_byte_done,
  output logic                       busy,
  output logic [GrantIdWidth-1:0]    grant_id,
  output logic [15:0]                sent_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  localparam logic [GrantIdWidth-1:0] LastIdx = GrantIdWidth'(NumRequesters - 1);

  state_t                  state;
  logic [GrantIdWidth-1:0] rr_ptr;
  logic [GrantIdWidth-1:0] win_idx;
  logic [GrantIdWidth-1:0] win_next;
  logic [7:0]              win_byte;
  logic                    win_found;
  logic                    grant;

  // Search upward from rr_ptr, wrapping at NumRequesters-1 back to 0; the
  // first set req_valid bit wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_byte  = 8'h00;
    for (int k = 0; k < NumRequesters; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NumRequesters) begin
        idx = idx - NumRequesters;
      end
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GrantIdWidth'(idx);
        win_byte  = req_byte[idx*8 +: 8];
      end
    end
  end

  assign win_next = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;

  // A transmitter still finishing (done low) blocks the grant, even in IDLE.
  assign grant = (state == IDLE) && tx_byte_done && win_found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tx_byte       <= 8'h00;
      tx_byte_valid <= 1'b0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      sent_count    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          tx_byte_valid <= 1'b0;
          if (grant) begin
            tx_byte       <= win_byte;
            grant_id      <= win_idx;
            rr_ptr        <= win_next;
            tx_byte_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // Pulse lasts exactly this cycle; the transmitter may not yet have
          // dropped done, so never re-enter IDLE from here.
          tx_byte_valid <= 1'b0;
          state         <= WAIT_LOW;
        end
        WAIT_LOW: begin
          tx_byte_valid <= 1'b0;
          if (!tx_byte_done) begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          tx_byte_valid <= 1'b0;
          if (tx_byte_done) begin
            sent_count <= sent_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: begin
          tx_byte_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
